// File: rtl/spu_rf_if.sv
// Operand-fetch / writeback bundle between the SPU-Lite pipes and the register file.
// The master side drives addresses and writebacks; the slave side returns registered operand data.
interface spu_rf_if #(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128
);
    logic [REG_ADDR_WD-1:0] ev_ra_addr;
    logic [REG_ADDR_WD-1:0] ev_rb_addr;
    logic [REG_ADDR_WD-1:0] ev_rc_addr;
    logic [REG_ADDR_WD-1:0] od_ra_addr;
    logic [REG_ADDR_WD-1:0] od_rb_addr;
    logic [REG_ADDR_WD-1:0] od_rc_addr;
    logic                   ev_wr_en;
    logic [REG_ADDR_WD-1:0] ev_wr_addr;
    logic [REG_DATA_WD-1:0] ev_wr_data;
    logic                   od_wr_en;
    logic [REG_ADDR_WD-1:0] od_wr_addr;
    logic [REG_DATA_WD-1:0] od_wr_data;
    logic [REG_DATA_WD-1:0] ev_ra_data;
    logic [REG_DATA_WD-1:0] ev_rb_data;
    logic [REG_DATA_WD-1:0] ev_rc_data;
    logic [REG_DATA_WD-1:0] od_ra_data;
    logic [REG_DATA_WD-1:0] od_rb_data;
    logic [REG_DATA_WD-1:0] od_rc_data;
    logic                   wr_collision;

    modport master (
        output ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr,
        output ev_wr_en, ev_wr_addr, ev_wr_data, od_wr_en, od_wr_addr, od_wr_data,
        input  ev_ra_data, ev_rb_data, ev_rc_data, od_ra_data, od_rb_data, od_rc_data,
        input  wr_collision
    );

    modport slave (
        input  ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr,
        input  ev_wr_en, ev_wr_addr, ev_wr_data, od_wr_en, od_wr_addr, od_wr_data,
        output ev_ra_data, ev_rb_data, ev_rc_data, od_ra_data, od_rb_data, od_rc_data,
        output wr_collision
    );
endinterface

// File: rtl/spu_reg_file.sv
// 128 x 128-bit SPU-Lite register file: six registered read ports, two write ports,
// same-edge write-through bypass; the odd pipe wins on a write collision (later in program order).
module spu_reg_file #(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128,
    parameter int NUM_REGS    = 128
) (
    input  logic     clk,
    input  logic     rst,
    spu_rf_if.slave  rf
);
    localparam int NUM_RD = 6;

    logic [REG_DATA_WD-1:0] mem_r     [NUM_REGS];
    logic [REG_ADDR_WD-1:0] rd_addr_s [NUM_RD];
    logic [REG_DATA_WD-1:0] rd_next_s [NUM_RD];
    logic [REG_DATA_WD-1:0] rd_data_r [NUM_RD];
    logic                   collision_s;
    logic                   wr_collision_r;

    // Value a read of addr observes on this edge: odd write, else even write, else stored contents.
    function automatic logic [REG_DATA_WD-1:0] fwd_sel(
        input logic [REG_ADDR_WD-1:0] addr,
        input logic [REG_DATA_WD-1:0] stored,
        input logic                   ev_en,
        input logic [REG_ADDR_WD-1:0] ev_addr,
        input logic [REG_DATA_WD-1:0] ev_data,
        input logic                   od_en,
        input logic [REG_ADDR_WD-1:0] od_addr,
        input logic [REG_DATA_WD-1:0] od_data
    );
        logic [REG_DATA_WD-1:0] val;
        if (od_en && (od_addr == addr)) begin
            val = od_data;
        end else if (ev_en && (ev_addr == addr)) begin
            val = ev_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign rd_addr_s[0] = rf.ev_ra_addr;
    assign rd_addr_s[1] = rf.ev_rb_addr;
    assign rd_addr_s[2] = rf.ev_rc_addr;
    assign rd_addr_s[3] = rf.od_ra_addr;
    assign rd_addr_s[4] = rf.od_rb_addr;
    assign rd_addr_s[5] = rf.od_rc_addr;

    // Collision detect: both pipes writing the same register on this edge.
    always_comb begin
        if (rf.ev_wr_en && rf.od_wr_en && (rf.ev_wr_addr == rf.od_wr_addr)) begin
            collision_s = 1'b1;
        end else begin
            collision_s = 1'b0;
        end
    end

    // Next operand values including write-through bypass.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next_s[i] = fwd_sel(rd_addr_s[i], mem_r[rd_addr_s[i]],
                                   rf.ev_wr_en, rf.ev_wr_addr, rf.ev_wr_data,
                                   rf.od_wr_en, rf.od_wr_addr, rf.od_wr_data);
        end
    end

    // Register array: writes discarded during reset, even write suppressed on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {REG_DATA_WD{1'b0}};
            end
        end else begin
            if (rf.ev_wr_en && !collision_s) begin
                mem_r[rf.ev_wr_addr] <= rf.ev_wr_data;
            end
            if (rf.od_wr_en) begin
                mem_r[rf.od_wr_addr] <= rf.od_wr_data;
            end
        end
    end

    // Operand output registers and collision pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_r[i] <= {REG_DATA_WD{1'b0}};
            end
            wr_collision_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_r[i] <= rd_next_s[i];
            end
            wr_collision_r <= collision_s;
        end
    end

    assign rf.ev_ra_data   = rd_data_r[0];
    assign rf.ev_rb_data   = rd_data_r[1];
    assign rf.ev_rc_data   = rd_data_r[2];
    assign rf.od_ra_data   = rd_data_r[3];
    assign rf.od_rb_data   = rd_data_r[4];
    assign rf.od_rc_data   = rd_data_r[5];
    assign rf.wr_collision = wr_collision_r;
endmodule

// File: tb/tb_spu_reg_file.sv
// Self-checking bench for spu_reg_file: a register-array model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_spu_reg_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    spu_rf_if bus ();

    spu_reg_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: architectural register contents and the outputs they imply.
    logic [127:0] m_mem  [128];
    logic [127:0] exp_rd [6];
    logic         exp_col;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [127:0] dut_rd(input int p);
        logic [127:0] v;
        case (p)
            0:       v = bus.ev_ra_data;
            1:       v = bus.ev_rb_data;
            2:       v = bus.ev_rc_data;
            3:       v = bus.od_ra_data;
            4:       v = bus.od_rb_data;
            default: v = bus.od_rc_data;
        endcase
        return v;
    endfunction

    // Model: apply writes in program order (even then odd), then every read sees the result.
    initial begin
        for (int i = 0; i < 128; i++) m_mem[i] = 128'd0;
        for (int p = 0; p < 6; p++) exp_rd[p] = 128'd0;
        exp_col = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 128; i++) m_mem[i] = 128'd0;
                for (int p = 0; p < 6; p++) exp_rd[p] = 128'd0;
                exp_col = 1'b0;
            end else begin
                exp_col = bus.ev_wr_en && bus.od_wr_en && (bus.ev_wr_addr == bus.od_wr_addr);
                if (bus.ev_wr_en) m_mem[bus.ev_wr_addr] = bus.ev_wr_data;
                if (bus.od_wr_en) m_mem[bus.od_wr_addr] = bus.od_wr_data;
                exp_rd[0] = m_mem[bus.ev_ra_addr];
                exp_rd[1] = m_mem[bus.ev_rb_addr];
                exp_rd[2] = m_mem[bus.ev_rc_addr];
                exp_rd[3] = m_mem[bus.od_ra_addr];
                exp_rd[4] = m_mem[bus.od_rb_addr];
                exp_rd[5] = m_mem[bus.od_rc_addr];
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < 6; p++) chk($sformatf("model_rd%0d", p), dut_rd(p), exp_rd[p]);
            chk("model_col", {127'd0, bus.wr_collision}, {127'd0, exp_col});
        end
    end

    task automatic idle();
        bus.ev_wr_en = 1'b0;
        bus.od_wr_en = 1'b0;
    endtask

    task automatic set_rd(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                          input logic [6:0] a3, input logic [6:0] a4, input logic [6:0] a5);
        bus.ev_ra_addr = a0;
        bus.ev_rb_addr = a1;
        bus.ev_rc_addr = a2;
        bus.od_ra_addr = a3;
        bus.od_rb_addr = a4;
        bus.od_rc_addr = a5;
    endtask

    logic [127:0] v_aa;
    logic [127:0] v_basic;
    logic [127:0] v_byp;

    initial begin
        checks  = 0;
        errors  = 0;
        v_aa    = {16{8'hAA}};
        v_basic = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        v_byp   = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0001;
        rst = 1'b1;
        idle();
        bus.ev_wr_addr = 7'd0;
        bus.ev_wr_data = 128'd0;
        bus.od_wr_addr = 7'd0;
        bus.od_wr_data = 128'd0;
        set_rd(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        repeat (2) @(negedge clk);
        chk("reset_out", bus.ev_ra_data, 128'd0);
        rst = 1'b0;

        // Basic write through even port, then read on all six ports.
        bus.ev_wr_en = 1'b1; bus.ev_wr_addr = 7'd3; bus.ev_wr_data = v_basic;
        @(negedge clk);
        idle();
        set_rd(7'd3, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3);
        @(negedge clk);
        for (int p = 0; p < 6; p++) chk($sformatf("basic_rd%0d", p), dut_rd(p), v_basic);

        // Same-edge bypass on odd write to the top register.
        bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'd127; bus.od_wr_data = v_byp;
        bus.od_ra_addr = 7'd127;
        @(negedge clk);
        idle();
        chk("bypass_od_ra", bus.od_ra_data, v_byp);
        chk("bypass_ev_ra_old", bus.ev_ra_data, v_basic);

        // Collision: odd wins, bypass returns odd data, pulse for one cycle.
        bus.ev_wr_en = 1'b1; bus.ev_wr_addr = 7'd10; bus.ev_wr_data = 128'h1;
        bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'd10; bus.od_wr_data = 128'h2;
        bus.ev_rb_addr = 7'd10;
        @(negedge clk);
        idle();
        chk("coll_pulse", {127'd0, bus.wr_collision}, 128'd1);
        chk("coll_bypass", bus.ev_rb_data, 128'h2);
        bus.ev_ra_addr = 7'd10;
        @(negedge clk);
        chk("coll_clear", {127'd0, bus.wr_collision}, 128'd0);
        chk("coll_stored", bus.ev_ra_data, 128'h2);

        // Distinct same-edge writes, including register 0.
        bus.ev_wr_en = 1'b1; bus.ev_wr_addr = 7'd0; bus.ev_wr_data = 128'h5;
        bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'd1; bus.od_wr_data = 128'h6;
        @(negedge clk);
        idle();
        chk("dual_nocoll", {127'd0, bus.wr_collision}, 128'd0);
        set_rd(7'd0, 7'd1, 7'd127, 7'd1, 7'd0, 7'd3);
        @(negedge clk);
        chk("dual_r0", bus.ev_ra_data, 128'h5);
        chk("dual_r1", bus.od_ra_data, 128'h6);
        chk("dual_r127", bus.ev_rc_data, v_byp);

        // Model-checked sweep of writes on both pipes with reads trailing by one register.
        for (int i = 0; i < 8; i++) begin
            bus.ev_wr_en = 1'b1; bus.ev_wr_addr = 7'(20 + i); bus.ev_wr_data = {4{32'(i * 17 + 1)}};
            bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'(40 + i); bus.od_wr_data = {4{32'(i * 29 + 3)}};
            set_rd(7'(20 + i), 7'(19 + i), 7'(40 + i), 7'(39 + i), 7'(20 + i), 7'd10);
            @(negedge clk);
        end
        idle();
        set_rd(7'd23, 7'd47, 7'd0, 7'd0, 7'd0, 7'd0);
        @(negedge clk);
        chk("sweep_r23", bus.ev_ra_data, {4{32'd52}});
        chk("sweep_r47", bus.ev_rb_data, {4{32'd206}});

        // Asynchronous reset mid-cycle after writing register 5.
        bus.ev_wr_en = 1'b1; bus.ev_wr_addr = 7'd5; bus.ev_wr_data = v_aa;
        @(negedge clk);
        idle();
        set_rd(7'd5, 7'd5, 7'd5, 7'd5, 7'd5, 7'd5);
        @(negedge clk);
        chk("pre_reset_r5", bus.od_rc_data, v_aa);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int p = 0; p < 6; p++) chk($sformatf("async_rst_rd%0d", p), dut_rd(p), 128'd0);
        chk("async_rst_col", {127'd0, bus.wr_collision}, 128'd0);

        // Write attempted while reset is held must be discarded.
        bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'd9; bus.od_wr_data = 128'h7;
        repeat (2) @(negedge clk);
        idle();
        rst = 1'b0;
        set_rd(7'd5, 7'd9, 7'd3, 7'd9, 7'd5, 7'd10);
        @(negedge clk);
        chk("post_rst_r5", bus.ev_ra_data, 128'd0);
        chk("post_rst_r9", bus.ev_rb_data, 128'd0);
        chk("post_rst_r3", bus.ev_rc_data, 128'd0);

        // First edge after release performs a write normally.
        bus.od_wr_en = 1'b1; bus.od_wr_addr = 7'd9; bus.od_wr_data = 128'h7;
        @(negedge clk);
        idle();
        chk("first_edge_bypass", bus.od_ra_data, 128'h7);
        @(negedge clk);
        chk("first_edge_stored", bus.ev_rb_data, 128'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
